// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) encodings, stage FSM states and helpers.
package ncl_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL  = 2'b00;
  localparam dr_t DR_DATA0 = 2'b01;
  localparam dr_t DR_DATA1 = 2'b10;

  // EMPTY: waiting for a carry wavefront; FULL: outputs hold DATA;
  // DRAIN: outputs NULL, waiting for the upstream carry to return to NULL.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    DRAIN = 2'b10
  } stage_state_t;

  // True only for the two legal DATA codes; NULL and 2'b11 are not data.
  function automatic logic dr_is_data(input dr_t d);
    return (d == DR_DATA0) || (d == DR_DATA1);
  endfunction

  // Encode a single bit as a dual-rail DATA code.
  function automatic dr_t dr_encode(input logic v);
    return v ? DR_DATA1 : DR_DATA0;
  endfunction

endpackage

// File: rtl/ncl_gates.sv
// Combinational NCL helper gates shared by the counter stage and benches.
//   ncl_th12   : 2-input threshold gate, any-rail completion detect.
//   ncl_thnotn : inverted completion with init gating; drives the DATA1 rail
//                of the constant source feeding stage 0.

module ncl_th12 (
  input  logic a,
  input  logic b,
  output logic out
);
  assign out = a | b;
endmodule

module ncl_thnotn (
  input  logic in,
  input  logic init,
  output logic out
);
  // Held low during init so the source presents NULL while the ring resets.
  assign out = ~in & ~init;
endmodule

// File: rtl/two_d_int_counter_ring.sv
// One-bit dual-rail ripple-counter digit with a clocked four-phase
// completeness handshake. Chain carryout -> carryin to build N-bit counters.
// Optional macro DUAL_RAIL_CHECK_EN adds a sticky proto_err output that flags
// illegal carry codes and completions rising while the outputs are NULL.

module two_d_int_counter_ring
  import ncl_pkg::*;
#(
  parameter logic INIT_STATE = 1'b0
) (
  input  logic clk,
  input  logic init,
  output dr_t  sum,
  input  logic sumcomp,
  output dr_t  carryout,
  input  logic carryoutcomp,
  input  dr_t  carryin,
  output logic carryincomp
`ifdef DUAL_RAIL_CHECK_EN
  ,
  output logic proto_err
`endif
);

  stage_state_t state, state_nxt;
  logic         state_bit, bit_nxt;
  dr_t          sum_nxt, carry_nxt;
  logic         cin_any;
  logic         cin_one;

  // Any rail high means the upstream carry has not yet returned to NULL.
  ncl_th12 u_cin_detect (
    .a   (carryin[0]),
    .b   (carryin[1]),
    .out (cin_any)
  );

  assign cin_one = carryin[1];

  // Next-state and next-output decode for the EMPTY/FULL/DRAIN handshake.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which keeps this block purely combinational (no inferred latches).
    state_nxt = state;
    bit_nxt   = state_bit;
    sum_nxt   = sum;
    carry_nxt = carryout;
    unique case (state)
      EMPTY: begin
        // Capture only a legal DATA code with both consumers idle; 2'b11 holds.
        if (dr_is_data(carryin) && !sumcomp && !carryoutcomp) begin
          sum_nxt   = dr_encode(state_bit ^ cin_one);
          carry_nxt = dr_encode(state_bit & cin_one);
          bit_nxt   = state_bit ^ cin_one;
          state_nxt = FULL;
        end
      end
      FULL: begin
        // Both outputs return to NULL together, never individually.
        if (sumcomp && carryoutcomp) begin
          sum_nxt   = DR_NULL;
          carry_nxt = DR_NULL;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!cin_any) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State, stored bit and registered outputs; init overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (init) begin
      state       <= EMPTY;
      state_bit   <= INIT_STATE;
      sum         <= DR_NULL;
      carryout    <= DR_NULL;
      carryincomp <= 1'b0;
    end else begin
      state       <= state_nxt;
      state_bit   <= bit_nxt;
      sum         <= sum_nxt;
      carryout    <= carry_nxt;
      carryincomp <= (state_nxt != EMPTY);
    end
  end

`ifdef DUAL_RAIL_CHECK_EN
  logic sumcomp_q, carryoutcomp_q;
  logic comp_rise;

  assign comp_rise = (sumcomp & ~sumcomp_q) | (carryoutcomp & ~carryoutcomp_q);

  // Sticky protocol error: illegal carry code or a completion rising on NULL outputs.
  always_ff @(posedge clk) begin
    if (init) begin
      proto_err      <= 1'b0;
      sumcomp_q      <= 1'b0;
      carryoutcomp_q <= 1'b0;
    end else begin
      sumcomp_q      <= sumcomp;
      carryoutcomp_q <= carryoutcomp;
      if ((carryin == 2'b11) || (comp_rise && !dr_is_data(sum))) proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_two_d_int_counter_ring.sv
// Bench for two_d_int_counter_ring: a directly driven single stage followed
// by a 4-stage ring fed from ncl_thnotn and terminated with ncl_th12 sinks.
// Build with DUAL_RAIL_CHECK_EN defined to also exercise proto_err.

module tb_two_d_int_counter_ring;
  import ncl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single stage under direct control.
  logic init;
  dr_t  carryin;
  logic sumcomp, carryoutcomp;
  dr_t  sum, carryout;
  logic carryincomp;
`ifdef DUAL_RAIL_CHECK_EN
  logic proto_err;
`endif

  two_d_int_counter_ring #(.INIT_STATE(1'b0)) dut (
    .clk          (clk),
    .init         (init),
    .sum          (sum),
    .sumcomp      (sumcomp),
    .carryout     (carryout),
    .carryoutcomp (carryoutcomp),
    .carryin      (carryin),
    .carryincomp  (carryincomp)
`ifdef DUAL_RAIL_CHECK_EN
    ,
    .proto_err    (proto_err)
`endif
  );

  // Four-stage ring.
  logic chain_init;
  logic src_rail1;
  dr_t  ch_carry [5];
  logic ch_cincomp [5];
  dr_t  ch_sum [4];
  logic ch_sumcomp [4];
`ifdef DUAL_RAIL_CHECK_EN
  logic ch_perr [4];
`endif

  ncl_thnotn u_src (.in(ch_cincomp[0]), .init(chain_init), .out(src_rail1));
  assign ch_carry[0] = {src_rail1, 1'b0};
  ncl_th12 u_end (.a(ch_carry[4][0]), .b(ch_carry[4][1]), .out(ch_cincomp[4]));

  for (genvar g = 0; g < 4; g++) begin : g_stage
    two_d_int_counter_ring #(.INIT_STATE(1'b0)) u_stage (
      .clk          (clk),
      .init         (chain_init),
      .sum          (ch_sum[g]),
      .sumcomp      (ch_sumcomp[g]),
      .carryout     (ch_carry[g+1]),
      .carryoutcomp (ch_cincomp[g+1]),
      .carryin      (ch_carry[g]),
      .carryincomp  (ch_cincomp[g])
`ifdef DUAL_RAIL_CHECK_EN
      ,
      .proto_err    (ch_perr[g])
`endif
    );
    ncl_th12 u_sink (.a(ch_sum[g][0]), .b(ch_sum[g][1]), .out(ch_sumcomp[g]));
  end

  // Scoreboards: {expected sum, expected carryout}.
  logic [3:0] sb_q [$];
  logic [3:0] ch_q [4][$];
  logic [3:0] last_exp;
  logic       m_bit;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one digit: push the outputs the next capture must give.
  task automatic push_wave(input dr_t c);
    logic v;
    v = (c == 2'b10);
    sb_q.push_back({(m_bit ^ v) ? 2'b10 : 2'b01, (m_bit & v) ? 2'b10 : 2'b01});
    m_bit = m_bit ^ v;
  endtask

  task automatic expect_out(input string tag);
    check({tag, "_avail"}, 8'(sb_q.size() != 0), 8'd1);
    if (sb_q.size() != 0) begin
      last_exp = sb_q.pop_front();
      check(tag, 8'({sum, carryout}), 8'(last_exp));
    end
  endtask

  // One full four-phase handshake on the single stage with auto-ack sinks.
  task automatic wavefront(input dr_t c, input string tag);
    carryin = c; sumcomp = 1'b0; carryoutcomp = 1'b0;
    push_wave(c);
    tick();
    expect_out(tag);
    check({tag, "_cic"}, 8'(carryincomp), 8'd1);
    check({tag, "_bit"}, 8'(dut.state_bit), 8'(m_bit));
    sumcomp = 1'b1; carryoutcomp = 1'b1;
    tick();
    check({tag, "_rel"}, 8'({sum, carryout}), 8'd0);
    check({tag, "_rel_cic"}, 8'(carryincomp), 8'd1);
    carryin = DR_NULL;
    tick();
    check({tag, "_cic_fall"}, 8'(carryincomp), 8'd0);
    sumcomp = 1'b0; carryoutcomp = 1'b0;
  endtask

  initial begin
    int   waves;
    int   done3;
    logic prev_cic0;
    logic prev_data [4];

    init = 1'b1; carryin = DR_DATA1; sumcomp = 1'b0; carryoutcomp = 1'b0;
    chain_init = 1'b1;
    m_bit = 1'b0;

    // Reset with DATA1 already on carryin: it must be ignored while init is high.
    tick(); tick();
    check("rst_outs", 8'({sum, carryout}), 8'd0);
    check("rst_cic", 8'(carryincomp), 8'd0);
    check("rst_bit", 8'(dut.state_bit), 8'd0);
    init = 1'b0;

    wavefront(DR_DATA1, "w1_d1");   // bit 0 -> 1: sum DATA1, carry DATA0
    wavefront(DR_DATA1, "w2_d1");   // bit 1 -> 0: sum DATA0, carry DATA1
    wavefront(DR_DATA1, "w3_d1");   // bit 0 -> 1
    wavefront(DR_DATA0, "w4_d0");   // bit stays 1: sum DATA1, carry DATA0
`ifdef DUAL_RAIL_CHECK_EN
    check("perr_clean", 8'(proto_err), 8'd0);
`endif

    // Stall: sum consumer withholds completion for 10 cycles.
    carryin = DR_DATA1;
    push_wave(DR_DATA1);
    tick();
    expect_out("stall_cap");
    carryoutcomp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 8'({sum, carryout}), 8'(last_exp));
    end
    sumcomp = 1'b1;
    tick();
    check("stall_rel", 8'({sum, carryout}), 8'd0);
    // carryin still DATA: the same wavefront must not be captured twice.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("no_dup_outs", 8'({sum, carryout}), 8'd0);
      check("no_dup_cic", 8'(carryincomp), 8'd1);
    end
    carryin = DR_NULL;
    tick();
    check("stall_cic_fall", 8'(carryincomp), 8'd0);
    sumcomp = 1'b0; carryoutcomp = 1'b0;

    // Illegal carry code is held, never captured.
    carryin = 2'b11;
    tick(); tick(); tick();
    check("ill_outs", 8'({sum, carryout}), 8'd0);
    check("ill_cic", 8'(carryincomp), 8'd0);
    check("ill_bit", 8'(dut.state_bit), 8'(m_bit));
`ifdef DUAL_RAIL_CHECK_EN
    check("perr_set", 8'(proto_err), 8'd1);
`endif

    // Capture blocked while the sum consumer still signals completion.
    carryin = DR_DATA1; sumcomp = 1'b1;
    tick();
    check("blk_outs", 8'({sum, carryout}), 8'd0);
    check("blk_cic", 8'(carryincomp), 8'd0);
    sumcomp = 1'b0;
    push_wave(DR_DATA1);
    tick();
    expect_out("late_cap");

    // Reset mid-wavefront with outputs DATA.
    init = 1'b1;
    tick();
    check("mid_rst_outs", 8'({sum, carryout}), 8'd0);
    check("mid_rst_cic", 8'(carryincomp), 8'd0);
    check("mid_rst_bit", 8'(dut.state_bit), 8'd0);
`ifdef DUAL_RAIL_CHECK_EN
    check("perr_cleared", 8'(proto_err), 8'd0);
`endif
    carryin = DR_NULL;
    m_bit = 1'b0;
    tick();
    init = 1'b0;

    // Four-stage ring: stage i of wavefront k emits bit i of k mod 16 and a
    // DATA1 carry exactly when the low i+1 bits of k wrap to zero.
    tick(); tick();
    chain_init = 1'b0;
    waves = 0; done3 = 0; prev_cic0 = 1'b0;
    for (int i = 0; i < 4; i++) prev_data[i] = 1'b0;
    for (int cyc = 0; cyc < 4000 && done3 < 20; cyc++) begin
      @(negedge clk);
      if (ch_cincomp[0] && !prev_cic0) begin
        waves++;
        for (int i = 0; i < 4; i++) begin
          ch_q[i].push_back({((waves >> i) & 1) != 0 ? 2'b10 : 2'b01,
                             (waves % (1 << (i + 1))) == 0 ? 2'b10 : 2'b01});
        end
      end
      prev_cic0 = ch_cincomp[0];
      for (int i = 0; i < 4; i++) begin
        if (dr_is_data(ch_sum[i]) && !prev_data[i]) begin
          check($sformatf("ch%0d_avail", i), 8'(ch_q[i].size() != 0), 8'd1);
          if (ch_q[i].size() != 0)
            check($sformatf("ch%0d_out", i), 8'({ch_sum[i], ch_carry[i+1]}),
                  8'(ch_q[i].pop_front()));
          if (i == 3) done3++;
        end
        prev_data[i] = dr_is_data(ch_sum[i]);
      end
    end
    check("chain_done", 8'(done3), 8'd20);
`ifdef DUAL_RAIL_CHECK_EN
    for (int i = 0; i < 4; i++) check($sformatf("ch%0d_perr", i), 8'(ch_perr[i]), 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/two_d_int_counter_ring.md
Name: two_d_int_counter_ring

Overview:
- One-bit digit of a dual-rail ripple counter, pipelined by a clocked model of the NCL four-phase completeness handshake.
- Each stage holds one state bit and accepts one carry-in wavefront per count step.
- For each wavefront it emits a sum digit and a carry-out digit, then updates its bit.
- Stages chain carry-out to carry-in to form N-bit counters. Stage 0 is fed by a constant-DATA1 source; the final carry-out and every sum go to completion sinks.

Parameters:
- INIT_STATE, 1'b0, value of the stored bit after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- init  in  1  synchronous active-high reset.
- sum  out  2  dual-rail sum digit: 2'b00 NULL, 2'b01 DATA0, 2'b10 DATA1.
- sumcomp  in  1  sum consumer completion; high means data received, NULL requested.
- carryout  out  2  dual-rail carry to the next stage.
- carryoutcomp  in  1  completion from the next stage.
- carryin  in  2  dual-rail carry from the previous stage or source.
- carryincomp  out  1  completion to the upstream stage.

Behaviour:
- Reset (init=1 at an edge): sum=NULL, carryout=NULL, carryincomp=0, bit=INIT_STATE. Reset overrides everything, including mid-wavefront; all inputs are ignored while init is high.
- Capture (DATA phase), one edge:
  - Condition: carryin is DATA, sum and carryout are NULL, carryincomp=0, sumcomp=0, carryoutcomp=0.
  - Action: sum <= bit XOR c; carryout <= bit AND c; bit <= bit XOR c; carryincomp <= 1.
  - c = 1 for DATA1, 0 for DATA0. DATA0 leaves bit unchanged and gives sum = bit.
- Release (NULL phase): when outputs are DATA and both sumcomp=1 and carryoutcomp=1 at an edge, sum and carryout return to NULL together. Outputs never go NULL individually.
- Upstream completion: carryincomp falls at the edge where carryin is NULL, outputs are NULL and carryincomp=1.
- Latency: carryin DATA to outputs DATA in 1 cycle when downstream is ready.
- Ordering: a full handshake is at least 4 edges (capture, release, carryincomp fall, next capture).
- Flow control: the stage stalls indefinitely with outputs held while downstream completions do not satisfy the rules. No data is dropped or duplicated.
- Illegal carryin 2'b11 is never captured; the stage holds.
- Outputs are registered; no combinational path from inputs to outputs.
- Sub-gates, combinational:
  - th12: out = a | b (dual-rail completion detect).
  - thnotn: out = ~in & ~init. Used as the stage-0 DATA1 rail source: rail1 = thnotn(carryincomp), rail0 = 0.

Optional Feature:
- DUAL_RAIL_CHECK_EN adds output proto_err (1 bit).
- proto_err is sticky and set at an edge where carryin==2'b11, or sumcomp/carryoutcomp rises while outputs are NULL. It is cleared only by init.
- Without the macro the port is absent and illegal codes are silently held.

Decomposition:
- Package ncl_pkg:
  - typedef dr_t (logic [1:0]).
  - Constants DR_NULL=2'b00, DR_DATA0=2'b01, DR_DATA1=2'b10.
  - Function dr_is_data().
- Sub-modules ncl_th12 (2-input OR completion) and ncl_thnotn (inverted completion source with init gating), used by the stage and by benches.
- Stage FSM states: EMPTY, FULL, DRAIN.
  - EMPTY -> FULL on capture.
  - FULL -> DRAIN on release.
  - DRAIN -> EMPTY when carryincomp falls.

Test Plan:
- Reset, INIT_STATE=0, carryin=DATA1, sinks auto-ack -> sum=2'b10, carryout=2'b01, carryincomp=1, bit=1.
- Second DATA1 wavefront after full NULL cycle -> sum=2'b01, carryout=2'b10, bit=0.
- carryin=DATA0 with bit=1 -> sum=2'b10, carryout=2'b01, bit stays 1.
- Hold sumcomp=0 with carryoutcomp=1 for 10 cycles -> outputs stay DATA. Raise sumcomp -> outputs NULL next edge.
- 4-stage chain, stage 0 fed via ncl_thnotn, ends via ncl_th12 -> after wavefront k the sum DATA across stages encodes k mod 16 (e.g., k=5 -> 0101). The chain wraps to 0000 with a DATA1 carry out of stage 3 on wavefront 16.
- Assert init mid-wavefront with outputs DATA -> next edge all NULL, carryincomp=0, bit=INIT_STATE. With DUAL_RAIL_CHECK_EN, carryin=2'b11 sets proto_err=1.
